// File: rtl/conv_encoder_k7.sv
// Rate-1/2 K=7 convolutional encoder with zero-tail termination and
// optional puncturing to rate 2/3 or 3/4, one coded symbol per beat.
module conv_encoder_k7 #(
  parameter int             K  = 7,
  parameter logic [K-1:0]   G0 = 7'o171,
  parameter logic [K-1:0]   G1 = 7'o133
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] rate_mode,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_bit,
  input  logic       in_last,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [1:0] out_sym,
  output logic [1:0] out_mask,
  output logic       out_last,
  output logic       busy
);

  localparam int TCW = $clog2(K - 1);
  localparam logic [TCW-1:0] TC_LAST = TCW'(K - 2);
  localparam logic [TCW-1:0] TC_ONE  = TCW'(1);

  typedef enum logic [1:0] {IDLE, DATA, TAIL} state_t;

  state_t         state;
  logic [K-2:0]   sr;
  logic [1:0]     pc;
  logic [TCW-1:0] tc;
  logic [1:0]     mode_r;

  logic           produce;
  logic           accept;
  logic           fire;
  logic [1:0]     mode_in;
  logic [1:0]     mode_cur;
  logic [K-2:0]   sr_cur;
  logic [1:0]     pc_cur;
  logic [1:0]     pc_next;
  logic [1:0]     mask;
  logic           b;
  logic [K-1:0]   w;
  logic           a_bit;
  logic           b_bit;

  assign busy = (state != IDLE);

  // A fresh frame starts from a cleared register and puncture phase, so IDLE
  // encodes against zeros instead of waiting a cycle for the clear to land.
  always_comb begin
    produce  = !out_valid || out_ready;
    in_ready = (state != TAIL) && produce;
    accept   = in_valid && in_ready;
    fire     = accept || ((state == TAIL) && produce);
    mode_in  = (rate_mode == 2'd3) ? 2'd0 : rate_mode;
    mode_cur = (state == IDLE) ? mode_in : mode_r;
    sr_cur   = (state == IDLE) ? '0 : sr;
    pc_cur   = (state == IDLE) ? 2'd0 : pc;
    b        = (state == TAIL) ? 1'b0 : in_bit;
    w        = {b, sr_cur};
    a_bit    = ^(w & G0);
    b_bit    = ^(w & G1);
    mask     = 2'b11;
    pc_next  = 2'd0;
    case (mode_cur)
      2'd1: begin
        mask    = (pc_cur == 2'd0) ? 2'b11 : 2'b01;
        pc_next = (pc_cur == 2'd1) ? 2'd0 : pc_cur + 2'd1;
      end
      2'd2: begin
        case (pc_cur)
          2'd0:    mask = 2'b11;
          2'd1:    mask = 2'b01;
          default: mask = 2'b10;
        endcase
        pc_next = (pc_cur == 2'd2) ? 2'd0 : pc_cur + 2'd1;
      end
      default: begin
        mask    = 2'b11;
        pc_next = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      sr        <= '0;
      pc        <= 2'd0;
      tc        <= '0;
      mode_r    <= 2'd0;
      out_valid <= 1'b0;
      out_sym   <= 2'b00;
      out_mask  <= 2'b00;
      out_last  <= 1'b0;
    end else if (fire) begin
      out_valid <= 1'b1;
      out_sym   <= {b_bit, a_bit} & mask;
      out_mask  <= mask;
      out_last  <= 1'b0;
      sr        <= {b, sr_cur[K-2:1]};
      pc        <= pc_next;
      case (state)
        IDLE: begin
          mode_r <= mode_in;
          tc     <= '0;
          state  <= in_last ? TAIL : DATA;
        end
        DATA: begin
          tc <= '0;
          if (in_last) state <= TAIL;
        end
        default: begin
          tc <= tc + TC_ONE;
          if (tc == TC_LAST) begin
            out_last <= 1'b1;
            state    <= IDLE;
          end
        end
      endcase
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv_encoder_k7.sv
// Self-checking bench for conv_encoder_k7: directed table vectors, hand-written
// corner sequences, and randomized frames against a convolution reference model.
module tb_conv_encoder_k7;

  localparam logic [6:0] G0 = 7'o171;
  localparam logic [6:0] G1 = 7'o133;

  logic       clk;
  logic       reset;
  logic [1:0] rate_mode;
  logic       in_valid;
  logic       in_ready;
  logic       in_bit;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_sym;
  logic [1:0] out_mask;
  logic       out_last;
  logic       busy;

  conv_encoder_k7 dut (
    .clk       (clk),
    .reset     (reset),
    .rate_mode (rate_mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bit    (in_bit),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sym   (out_sym),
    .out_mask  (out_mask),
    .out_last  (out_last),
    .busy      (busy)
  );

  typedef struct packed {
    logic [1:0] sym;
    logic [1:0] mask;
    logic       last;
  } beat_t;

  typedef struct {
    logic [1:0]  mode;
    int          nbits;
    logic [15:0] bits;
    int          nbeats;
    logic [39:0] syms;
    logic [39:0] masks;
  } vec_t;

  vec_t  vecs[5];
  beat_t exp_q[$];
  beat_t obs_q[$];
  int    frame_bits[64];
  int    n_vec;
  int    n_err;
  int    ready_mode;
  logic  stall_prev;
  logic [4:0] held;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Reference: direct convolution of the zero-padded bit stream with the
  // generator taps, punctured by beat position within the frame.
  task automatic model_frame(input int off, input int n, input int mode);
    int m;
    m = (mode == 3) ? 0 : mode;
    for (int t = 0; t < n + 6; t++) begin
      int a;
      int bb;
      int mk;
      beat_t e;
      a  = 0;
      bb = 0;
      for (int j = 0; j < 7; j++) begin
        int u;
        u = (t - j >= 0 && t - j < n) ? (frame_bits[off + t - j] & 1) : 0;
        a  = a  ^ (u & int'(G0[6 - j]));
        bb = bb ^ (u & int'(G1[6 - j]));
      end
      if (m == 1)      mk = (t % 2 == 0) ? 3 : 1;
      else if (m == 2) mk = (t % 3 == 0) ? 3 : ((t % 3 == 1) ? 1 : 2);
      else             mk = 3;
      e.sym  = 2'((bb * 2 + a) & mk);
      e.mask = 2'(mk);
      e.last = (t == n + 5);
      exp_q.push_back(e);
    end
  endtask

  task automatic apply_stimulus(input logic bv, input logic lv);
    logic got;
    got      = 1'b0;
    in_valid = 1'b1;
    in_bit   = bv;
    in_last  = lv;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk);
      #1;
      if (got) break;
    end
    if (!got) begin
      n_vec++;
      n_err++;
      $display("[TB] FAIL accept timeout: got in_ready 0, required 1");
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_frame(input int off, input int n, input int mode, input bit scramble);
    for (int i = 0; i < n; i++) begin
      if (i == 0)        rate_mode = 2'(mode);
      else if (scramble) rate_mode = 2'($urandom_range(0, 3));
      apply_stimulus(frame_bits[off + i][0], i == n - 1);
    end
  endtask

  task automatic drain(input string name);
    int lim;
    for (int k = 0; k < 4000 && obs_q.size() < exp_q.size(); k++) begin
      @(posedge clk);
      #1;
    end
    repeat (12) begin
      @(posedge clk);
      #1;
    end
    check_output({name, " beat count"}, obs_q.size(), exp_q.size());
    lim = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int k = 0; k < lim; k++) begin
      check_output($sformatf("%s beat%0d sym", name, k),  obs_q[k].sym,  exp_q[k].sym);
      check_output($sformatf("%s beat%0d mask", name, k), obs_q[k].mask, exp_q[k].mask);
      check_output($sformatf("%s beat%0d last", name, k), obs_q[k].last, exp_q[k].last);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic apply_vec(input int i);
    beat_t e;
    logic [39:0] s;
    logic [39:0] m;
    logic [15:0] bv;
    s  = vecs[i].syms;
    m  = vecs[i].masks;
    bv = vecs[i].bits;
    for (int k = 0; k < vecs[i].nbits; k++) frame_bits[k] = int'(bv[k]);
    for (int k = 0; k < vecs[i].nbeats; k++) begin
      e.sym  = s[2*k +: 2];
      e.mask = m[2*k +: 2];
      e.last = (k == vecs[i].nbeats - 1);
      exp_q.push_back(e);
    end
    send_frame(0, vecs[i].nbits, int'(vecs[i].mode), 1'b0);
    drain($sformatf("vec%0d", i));
  endtask

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 2) != 0);
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Beats are logged on the negedge before the edge that transfers them;
  // a stalled beat must reappear unchanged.
  initial begin
    stall_prev = 1'b0;
    held       = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          check_output("stall valid", out_valid, 1);
          check_output("stall hold", {out_sym, out_mask, out_last}, held);
        end
        if (out_valid && !out_ready) check_output("stall in_ready", in_ready, 0);
        if (out_valid && out_ready) obs_q.push_back('{out_sym, out_mask, out_last});
        stall_prev = out_valid && !out_ready;
        held       = {out_sym, out_mask, out_last};
      end
    end
  end

  initial begin
    n_vec      = 0;
    n_err      = 0;
    ready_mode = 0;
    reset      = 1'b1;
    rate_mode  = 2'd0;
    in_valid   = 1'b0;
    in_bit     = 1'b0;
    in_last    = 1'b0;

    vecs[0] = '{2'd0, 1, 16'h0001, 7,  40'h38F7,  40'h3FFF};
    vecs[1] = '{2'd1, 4, 16'h000D, 10, 40'h50247, 40'h77777};
    vecs[2] = '{2'd2, 1, 16'h0001, 7,  40'h38E7,  40'h39E7};
    vecs[3] = '{2'd3, 1, 16'h0001, 7,  40'h38F7,  40'h3FFF};
    vecs[4] = '{2'd0, 4, 16'h000D, 10, 40'hD8A47, 40'hFFFFF};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("reset out_valid", out_valid, 0);
    check_output("reset out_sym", out_sym, 0);
    check_output("reset out_mask", out_mask, 0);
    check_output("reset out_last", out_last, 0);
    check_output("reset busy", busy, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_output("idle in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    $display("[TB] table vectors");
    for (int i = 0; i < 5; i++) apply_vec(i);

    $display("[TB] impulse handshake timing");
    frame_bits[0] = 1;
    model_frame(0, 1, 0);
    rate_mode = 2'd0;
    apply_stimulus(1'b1, 1'b1);
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      check_output($sformatf("impulse c%0d out_valid", c), out_valid, 1);
      check_output($sformatf("impulse c%0d in_ready", c), in_ready, (c < 6) ? 0 : 1);
      check_output($sformatf("impulse c%0d busy", c), busy, (c < 6) ? 1 : 0);
    end
    @(posedge clk);
    #1;
    drain("impulse");

    $display("[TB] backpressure");
    for (int i = 0; i < 6; i++) frame_bits[i] = int'($urandom_range(0, 1));
    model_frame(0, 6, 2);
    fork
      send_frame(0, 6, 2, 1'b0);
      begin
        repeat (4) @(negedge clk);
        ready_mode = 2;
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
          check_output($sformatf("bp c%0d out_valid", c), out_valid, 1);
          check_output($sformatf("bp c%0d in_ready", c), in_ready, 0);
          @(negedge clk);
        end
        ready_mode = 0;
      end
    join
    drain("backpressure");

    $display("[TB] back-to-back frames");
    for (int i = 0; i < 5; i++) frame_bits[i] = int'($urandom_range(0, 1));
    for (int i = 0; i < 4; i++) frame_bits[32 + i] = int'($urandom_range(0, 1));
    frame_bits[0] = 1;
    model_frame(0, 5, 1);
    model_frame(32, 4, 2);
    send_frame(0, 5, 1, 1'b1);
    send_frame(32, 4, 2, 1'b1);
    drain("b2b");

    $display("[TB] reset during tail");
    rate_mode = 2'd0;
    apply_stimulus(1'b1, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check_output("midreset out_valid", out_valid, 0);
    check_output("midreset busy", busy, 0);
    check_output("midreset out_last", out_last, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    obs_q.delete();
    exp_q.delete();
    apply_vec(0);

    $display("[TB] random frames");
    ready_mode = 1;
    for (int f = 0; f < 40; f++) begin
      int n;
      int mode;
      n    = $urandom_range(1, 24);
      mode = $urandom_range(0, 3);
      for (int i = 0; i < n; i++) frame_bits[i] = int'($urandom_range(0, 1));
      model_frame(0, n, mode);
      send_frame(0, n, mode, 1'b1);
      if (f % 3 == 2) drain($sformatf("rand%0d", f));
    end
    drain("rand_final");
    ready_mode = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/conv_encoder_k7.md
Name: conv_encoder_k7

Overview:
- Rate-1/2, K=7 convolutional encoder with zero-tail termination and optional puncturing to rate 2/3 or 3/4.
- Transmit-side counterpart of the Viterbi decoder, which uses the same 64-state trellis and a 6-bit state index.
- Accepts one information bit per handshake and emits one 2-bit coded symbol per beat, with an erasure mask.
- The decoder depuncturer uses the mask to insert erasures.

Parameters:
- K, 7: constraint length; shift register holds K-1 bits.
- G0, 7'o171: generator polynomial for output A. Bit K-1 taps the current input; bit 0 taps the oldest delay.
- G1, 7'o133: generator polynomial for output B, same bit ordering.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- rate_mode  in  2  0 = rate 1/2, 1 = rate 2/3, 2 = rate 3/4, 3 = reserved (treated as 0)
- in_valid  in  1  information bit valid
- in_ready  out  1  encoder can accept a bit
- in_bit  in  1  information bit
- in_last  in  1  marks the final information bit of the frame
- out_valid  out  1  coded symbol valid
- out_ready  in  1  downstream accepts the symbol
- out_sym  out  2  bit0 = A, bit1 = B; punctured positions are driven 0
- out_mask  out  2  bit0 = A present, bit1 = B present
- out_last  out  1  marks the final tail symbol of the frame
- busy  out  1  high in DATA or TAIL state

Behaviour:
- Interface decision: one clock (clk); reset is synchronous and active-high (reset).
- Reset values: out_valid=0, out_sym=0, out_mask=0, out_last=0, busy=0; shift register sr[K-2:0]=0; puncture counter pc=0; tail counter tc=0; state=IDLE.
- Encoding window: w = {b, sr}, where b is the current input bit.
  - A = XOR-reduce(w & G0); B = XOR-reduce(w & G1).
  - After each encoded beat: sr <= {b, sr[K-2:1]}, so sr[K-2] is delay 1.
- Output stage: a single register.
  - A beat is produced when out_valid=0, or out_valid=1 and out_ready=1 in the same cycle (full throughput).
  - While out_valid=1 and out_ready=0, out_sym, out_mask and out_last hold stable.
- in_ready = (state==IDLE or DATA) and (!out_valid or out_ready).
  - An input bit is accepted when in_valid and in_ready are both high.
  - Latency from accept to out_valid is 1 cycle.
- State machine:
  - IDLE: on accept, latch rate_mode into mode_r, clear sr and pc, encode the bit.
    - in_last=1 -> TAIL with tc=0.
    - Otherwise -> DATA.
  - DATA: each accept encodes the bit; accept with in_last=1 -> TAIL with tc=0.
  - TAIL: in_ready=0.
    - Each producible beat encodes b=0 and increments tc.
    - The beat with tc=K-2 (the 6th tail beat) sets out_last=1 -> IDLE.
    - sr returns to 0 at the end of the tail.
- Puncturing: applies to every beat of the frame, tail included. pc advances once per produced beat.
  - mode 0: mask always 2'b11; pc unused.
  - mode 1: period 2, masks 11, 01.
  - mode 2: period 3, masks 11, 01, 10.
  - pc wraps to 0 at the end of its period. Masked-off out_sym bits are 0.
- rate_mode changes mid-frame are ignored; mode_r is fixed for the whole frame.
- in_valid is ignored in TAIL, and a bit presented there is not consumed. Upstream holds it until IDLE accepts it as the next frame's first bit.
- Back-to-back frames:
  - The cycle after out_last is produced, IDLE can accept.
  - There are no gaps other than the tail.
- Reset mid-frame: all state is abandoned and the reset values are restored; a pending output beat is dropped.
- A frame with N information bits yields exactly N+K-1 output beats.

Test Plan:
- Impulse, mode 0: in_bit 1 with in_last=1, out_ready=1 -> 7 beats, out_sym = 3,1,3,3,0,2,3, mask 3 on all beats, out_last only on beat 7. in_ready=0 during beats 2-7.
- Mode 1, bits 1,0,1,1 with last on bit 4 -> 10 beats, mask sequence 3,1,3,1,3,1,3,1,3,1. out_sym bit1=0 wherever the mask is 1.
- Mode 2, same impulse as scenario 1 -> masks 3,1,2,3,1,2,3 and out_sym 3,1,2,3,0,2,3.
- Backpressure: hold out_ready=0 for 5 cycles mid-frame -> out_sym and out_mask stable, in_ready=0. Beat sequence identical to the no-stall run, with no loss or duplication.
- Back-to-back frames in which the second frame uses a different rate_mode, with rate_mode toggled mid-frame -> each frame uses the mode latched at its first bit. pc and sr restart at each frame; tail counts are correct.
- Assert reset during TAIL beat 3 -> next cycle out_valid=0, busy=0. A new frame starts cleanly and its impulse response matches scenario 1.
